// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display fetch has priority, AXI gets a guaranteed slot
// after MAX_DISP_RUN consecutive display grants. BRAM has 1-cycle read latency.
module vram_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 600,
  parameter int MAX_DISP_RUN = 4
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [31:0]       disp_rdata,
  input  logic              axi_req,
  input  logic              axi_we,
  input  logic [ADDR_W-1:0] axi_addr,
  input  logic [31:0]       axi_wdata,
  input  logic [3:0]        axi_be,
  output logic              axi_gnt,
  output logic              axi_rvalid,
  output logic [31:0]       axi_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(MAX_DISP_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DISP_RUN);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {SRC_NONE, SRC_DISP, SRC_AXI} rd_src_e;

  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  rd_src_e          rd_src_q, rd_src_d;
  logic             oor_q, oor_d;

  logic disp_win, axi_win;
  logic disp_in_range, axi_in_range;

  assign disp_in_range = ({1'b0, disp_addr} < DEPTH_L);
  assign axi_in_range  = ({1'b0, axi_addr} < DEPTH_L);

  // Grants are suppressed while reset is held so nothing reaches the BRAM.
  always_comb begin
    disp_win = 1'b0;
    axi_win  = 1'b0;
    if (axi_aresetn) begin
      if (disp_req && (!axi_req || run_cnt_q != RUN_MAX)) begin
        disp_win = 1'b1;
      end else if (axi_req) begin
        axi_win = 1'b1;
      end
    end
  end

  assign disp_gnt = disp_win;
  assign axi_gnt  = axi_win;

  // Out-of-range accesses are granted but never enable the BRAM.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (disp_win && disp_in_range) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (axi_win && axi_in_range) begin
      mem_en   = 1'b1;
      mem_addr = axi_addr;
      if (axi_we) begin
        mem_we    = axi_be;
        mem_wdata = axi_wdata;
      end
    end
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (!axi_req || axi_win) begin
      run_cnt_d = '0;
    end else if (disp_win && run_cnt_q != RUN_MAX) begin
      run_cnt_d = run_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    rd_src_d = SRC_NONE;
    oor_d    = 1'b0;
    if (disp_win) begin
      rd_src_d = SRC_DISP;
      oor_d    = !disp_in_range;
    end else if (axi_win && !axi_we) begin
      rd_src_d = SRC_AXI;
      oor_d    = !axi_in_range;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      run_cnt_q <= '0;
      rd_src_q  <= SRC_NONE;
      oor_q     <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      rd_src_q  <= rd_src_d;
      oor_q     <= oor_d;
    end
  end

  // Read data is steered straight from the BRAM output using the registered tag.
  always_comb begin
    disp_rvalid = (rd_src_q == SRC_DISP);
    axi_rvalid  = (rd_src_q == SRC_AXI);
    disp_rdata  = (disp_rvalid && !oor_q) ? mem_rdata : 32'h0;
    axi_rdata   = (axi_rvalid && !oor_q) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural 600-word BRAM
// (read-first, byte writes, 1-cycle read latency).
module tb_vram_port_arbiter;

  logic        clk;
  logic        axi_aresetn;
  logic        disp_req;
  logic [9:0]  disp_addr;
  logic        disp_gnt, disp_rvalid;
  logic [31:0] disp_rdata;
  logic        axi_req, axi_we;
  logic [9:0]  axi_addr;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_be;
  logic        axi_gnt, axi_rvalid;
  logic [31:0] axi_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] vram [0:599];
  logic        loaded = 1'b0;

  vram_port_arbiter dut (
    .axi_aclk    (clk),
    .axi_aresetn (axi_aresetn),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_gnt    (disp_gnt),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .axi_req     (axi_req),
    .axi_we      (axi_we),
    .axi_addr    (axi_addr),
    .axi_wdata   (axi_wdata),
    .axi_be      (axi_be),
    .axi_gnt     (axi_gnt),
    .axi_rvalid  (axi_rvalid),
    .axi_rdata   (axi_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word 7 is preloaded differently so the byte-enable merge is visible.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int n = 0; n < 600; n++) vram[n] <= (n == 7) ? 32'h11223344 : 32'h41424300 + 32'(n);
      mem_rdata <= 32'h0;
      loaded    <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= vram[mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) vram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_req = 1'b0;
    axi_req  = 1'b0;
    axi_we   = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (disp_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_disp_gnt: got %b expected 0", disp_gnt); end
    checks++; if (axi_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_axi_gnt: got %b expected 0", axi_gnt); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 4'b0000) begin errors++; $display("[TB] FAIL reset_mem: got en=%b we=%b expected 0/0000", mem_en, mem_we); end
    checks++; if (disp_rvalid !== 1'b0 || axi_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b/%b expected 0/0", disp_rvalid, axi_rvalid); end
    checks++; if (disp_rdata !== 32'h0 || axi_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", disp_rdata, axi_rdata); end
    repeat (2) @(posedge clk);
    #1;
    idle();
    axi_aresetn = 1'b1;
  endtask

  task automatic test_display_only();
    for (int i = 0; i <= 4; i++) begin
      tick();
      if (i > 0) begin
        checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 32'h41424300 + 32'(i - 1)) begin errors++; $display("[TB] FAIL disp_only_rdata[%0d]: got v=%b %h expected 1 %h", i - 1, disp_rvalid, disp_rdata, 32'h41424300 + 32'(i - 1)); end
        checks++; if (axi_rvalid !== 1'b0 || axi_rdata !== 32'h0) begin errors++; $display("[TB] FAIL disp_only_axi_out: got v=%b %h expected 0 0", axi_rvalid, axi_rdata); end
      end
      if (i < 4) begin
        disp_req  = 1'b1;
        disp_addr = 10'(i);
      end else begin
        disp_req = 1'b0;
      end
      #1;
      if (i < 4) begin
        checks++; if (disp_gnt !== 1'b1 || axi_gnt !== 1'b0) begin errors++; $display("[TB] FAIL disp_only_gnt[%0d]: got %b/%b expected 1/0", i, disp_gnt, axi_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_addr !== 10'(i) || mem_we !== 4'b0000) begin errors++; $display("[TB] FAIL disp_only_mem[%0d]: got en=%b addr=%0d we=%b expected 1 %0d 0000", i, mem_en, mem_addr, mem_we, i); end
      end
    end
  endtask

  task automatic test_starvation_bound();
    tick();
    disp_req  = 1'b1;
    disp_addr = 10'd20;
    axi_req   = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 5) begin
        checks++; if (axi_rvalid !== 1'b1 || axi_rdata !== 32'h41424305) begin errors++; $display("[TB] FAIL starve_axi_rdata: got v=%b %h expected 1 41424305", axi_rvalid, axi_rdata); end
        checks++; if (disp_rvalid !== 1'b0 || disp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL starve_disp_quiet: got v=%b %h expected 0 0", disp_rvalid, disp_rdata); end
      end
      disp_req  = 1'b1;
      disp_addr = 10'(21 + k);
      axi_req   = (k < 5);
      axi_we    = 1'b0;
      axi_addr  = 10'd5;
      #1;
      if (k == 4) begin
        checks++; if (axi_gnt !== 1'b1 || disp_gnt !== 1'b0 || mem_addr !== 10'd5) begin errors++; $display("[TB] FAIL starve_axi_slot: got axi=%b disp=%b addr=%0d expected 1 0 5", axi_gnt, disp_gnt, mem_addr); end
      end else begin
        checks++; if (disp_gnt !== 1'b1 || axi_gnt !== 1'b0) begin errors++; $display("[TB] FAIL starve_disp_gnt[%0d]: got disp=%b axi=%b expected 1 0", k, disp_gnt, axi_gnt); end
      end
    end
    tick();
    idle();
  endtask

  task automatic test_byte_write();
    tick();
    axi_req   = 1'b1;
    axi_we    = 1'b1;
    axi_addr  = 10'd7;
    axi_wdata = 32'hDEADBEEF;
    axi_be    = 4'b0101;
    #1;
    checks++; if (axi_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 10'd7) begin errors++; $display("[TB] FAIL bw_grant: got gnt=%b en=%b addr=%0d expected 1 1 7", axi_gnt, mem_en, mem_addr); end
    checks++; if (mem_we !== 4'b0101 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL bw_wport: got we=%b wdata=%h expected 0101 deadbeef", mem_we, mem_wdata); end
    tick();
    checks++; if (axi_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL bw_no_rvalid: got %b expected 0", axi_rvalid); end
    axi_we = 1'b0;
    #1;
    checks++; if (axi_gnt !== 1'b1 || mem_we !== 4'b0000) begin errors++; $display("[TB] FAIL bw_read_gnt: got gnt=%b we=%b expected 1 0000", axi_gnt, mem_we); end
    tick();
    checks++; if (axi_rvalid !== 1'b1 || axi_rdata !== 32'h11AD33EF) begin errors++; $display("[TB] FAIL bw_readback: got v=%b %h expected 1 11ad33ef", axi_rvalid, axi_rdata); end
    idle();
  endtask

  task automatic test_out_of_range();
    tick();
    axi_req  = 1'b1;
    axi_we   = 1'b0;
    axi_addr = 10'd600;
    #1;
    checks++; if (axi_gnt !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("[TB] FAIL oor_axi_rd: got gnt=%b en=%b expected 1 0", axi_gnt, mem_en); end
    tick();
    checks++; if (axi_rvalid !== 1'b1 || axi_rdata !== 32'h0) begin errors++; $display("[TB] FAIL oor_axi_rdata: got v=%b %h expected 1 0", axi_rvalid, axi_rdata); end
    axi_req   = 1'b0;
    disp_req  = 1'b1;
    disp_addr = 10'd1023;
    #1;
    checks++; if (disp_gnt !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("[TB] FAIL oor_disp_rd: got gnt=%b en=%b expected 1 0", disp_gnt, mem_en); end
    tick();
    checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL oor_disp_rdata: got v=%b %h expected 1 0", disp_rvalid, disp_rdata); end
    disp_req  = 1'b0;
    axi_req   = 1'b1;
    axi_we    = 1'b1;
    axi_addr  = 10'd700;
    axi_wdata = 32'hFFFFFFFF;
    axi_be    = 4'b1111;
    #1;
    checks++; if (axi_gnt !== 1'b1 || mem_en !== 1'b0 || mem_we !== 4'b0000) begin errors++; $display("[TB] FAIL oor_axi_wr: got gnt=%b en=%b we=%b expected 1 0 0000", axi_gnt, mem_en, mem_we); end
    tick();
    idle();
    checks++; if (axi_rvalid !== 1'b0 || vram[188] !== 32'h414243BC) begin errors++; $display("[TB] FAIL oor_wr_dropped: got v=%b vram188=%h expected 0 414243bc", axi_rvalid, vram[188]); end
  endtask

  task automatic test_write_then_display();
    tick();
    axi_req   = 1'b1;
    axi_we    = 1'b1;
    axi_addr  = 10'd2;
    axi_wdata = 32'hCAFEF00D;
    axi_be    = 4'b1111;
    #1;
    checks++; if (axi_gnt !== 1'b1) begin errors++; $display("[TB] FAIL wtd_axi_gnt: got %b expected 1", axi_gnt); end
    tick();
    axi_req   = 1'b0;
    axi_we    = 1'b0;
    disp_req  = 1'b1;
    disp_addr = 10'd2;
    #1;
    checks++; if (disp_gnt !== 1'b1) begin errors++; $display("[TB] FAIL wtd_disp_gnt: got %b expected 1", disp_gnt); end
    tick();
    idle();
    checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL wtd_rdata: got v=%b %h expected 1 cafef00d", disp_rvalid, disp_rdata); end
  endtask

  task automatic test_reset_mid_read();
    tick();
    disp_req  = 1'b1;
    disp_addr = 10'd4;
    #1;
    checks++; if (disp_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rmr_gnt: got %b expected 1", disp_gnt); end
    tick();
    disp_req    = 1'b0;
    axi_aresetn = 1'b0;
    #1;
    checks++; if (disp_rvalid !== 1'b0 || disp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rmr_in_reset: got v=%b %h expected 0 0", disp_rvalid, disp_rdata); end
    axi_req  = 1'b1;
    axi_we   = 1'b0;
    axi_addr = 10'd6;
    #1;
    checks++; if (axi_gnt !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("[TB] FAIL rmr_gnt_held: got gnt=%b en=%b expected 0 0", axi_gnt, mem_en); end
    tick();
    tick();
    axi_aresetn = 1'b1;
    #1;
    checks++; if (disp_rvalid !== 1'b0 || axi_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rmr_no_rvalid: got %b/%b expected 0/0", disp_rvalid, axi_rvalid); end
    checks++; if (axi_gnt !== 1'b1 || mem_addr !== 10'd6) begin errors++; $display("[TB] FAIL rmr_first_gnt: got gnt=%b addr=%0d expected 1 6", axi_gnt, mem_addr); end
    tick();
    idle();
    checks++; if (axi_rvalid !== 1'b1 || axi_rdata !== 32'h41424306 || disp_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rmr_axi_rdata: got v=%b %h dv=%b expected 1 41424306 0", axi_rvalid, axi_rdata, disp_rvalid); end
  endtask

  initial begin
    axi_aresetn = 1'b0;
    disp_req    = 1'b1;
    disp_addr   = 10'd0;
    axi_req     = 1'b1;
    axi_we      = 1'b1;
    axi_addr    = 10'd3;
    axi_wdata   = 32'h12345678;
    axi_be      = 4'b1111;
    test_reset();
    test_display_only();
    test_starvation_bound();
    test_byte_write();
    test_out_of_range();
    test_write_then_display();
    test_reset_mid_read();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Shares the single-port character VRAM between two requesters: the display fetch engine, which reads 32-bit words holding four 8-bit character codes, and the AXI register slave, which reads and writes VRAM for the host CPU. The display path has priority. A bounded-run counter guarantees the AXI side is not starved. The block sits between the AXI slave logic, the text-mode pixel logic's word fetch, and the BRAM primitive (1-cycle read latency).

## Interface
- ADDR_W, 10, VRAM word address width
- DEPTH, 600, number of implemented words (80x30 chars / 4 per word); addresses >= DEPTH are out of range
- MAX_DISP_RUN, 4, max consecutive display grants while an AXI request is waiting
- axi_aclk  in  1  sole clock; all logic rising-edge
- axi_aresetn  in  1  asynchronous, active-low reset
- disp_req  in  1  display read request, held until granted
- disp_addr  in  ADDR_W  display word address
- disp_gnt  out  1  display request accepted this cycle
- disp_rvalid  out  1  disp_rdata valid
- disp_rdata  out  32  read word; byte k = character at column 4*word+k
- axi_req  in  1  AXI request, held with stable fields until granted
- axi_we  in  1  1 = write, 0 = read
- axi_addr  in  ADDR_W  AXI word address
- axi_wdata  in  32  write data
- axi_be  in  4  byte enables for writes
- axi_gnt  out  1  AXI request accepted this cycle
- axi_rvalid  out  1  axi_rdata valid (reads only)
- axi_rdata  out  32  read word
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, valid the cycle after mem_en

## Operation
- Arbitration is combinational on the current-cycle requests. At most one grant per cycle. A transfer occurs on req & gnt.
- Winner selection:
  - Only one requester active: that requester wins.
  - Both active: display wins, unless run_cnt == MAX_DISP_RUN, in which case AXI wins.
- run_cnt (registered, width clog2(MAX_DISP_RUN+1)):
  - Increments on each display grant while axi_req = 1.
  - Clears on any AXI grant, or in any cycle with axi_req = 0.
  - Saturates at MAX_DISP_RUN.
- Granted in-range access drives mem_en = 1 and mem_addr = the granted address.
  - AXI write: mem_we = axi_be, mem_wdata = axi_wdata.
  - Otherwise mem_we = 0.
- No grant: mem_en = 0, mem_we = 0. mem_addr and mem_wdata are don't-care but must be driven to 0.
- Out-of-range address (>= DEPTH):
  - The request is still granted. mem_en stays 0.
  - Reads return 32'h0 with normal rvalid timing.
  - Writes are dropped silently.
- Read-return tag (registered): rd_src ∈ {NONE, DISP, AXI}, plus an oor flag, captured at grant.
  - Next cycle, the matching rvalid = 1 for exactly one cycle.
  - rdata = oor ? 0 : mem_rdata.
  - The non-matching rdata holds 0.
- AXI writes never produce axi_rvalid.

## Timing
- Grant latency: 0 cycles (gnt combinational from req and run_cnt).
- Read latency: rvalid and rdata exactly 1 cycle after the grant cycle. Back-to-back grants give back-to-back rvalids.
- Write: memory updated at the clock edge ending the grant cycle. A read of the same address granted the next cycle returns the new data.
- Worst-case AXI wait with display requesting every cycle: MAX_DISP_RUN cycles before grant.
- Reset (axi_aresetn = 0, asynchronous):
  - run_cnt = 0, rd_src = NONE, disp_rvalid = axi_rvalid = 0, rdata = 0.
  - disp_gnt = axi_gnt = 0 and mem_en = mem_we = 0 while reset is asserted.
- Reset mid-read: the in-flight read is dropped and no rvalid is issued after release.
- First grant possible in the first cycle after deassertion.

## Test plan
- Display only: disp_req every cycle, addrs 0..3, BRAM preloaded with word n = 32'h41424300+n -> disp_gnt every cycle; disp_rvalid 1 cycle later with matching data; axi_* outputs stay 0.
- Contention starvation bound: disp_req constant, axi_req read addr 5 asserted at cycle 10 -> display granted cycles 10..13, axi_gnt at cycle 14, axi_rvalid at 15 with word 5; display resumes at cycle 15.
- Byte-enable write then read: AXI write addr 7, wdata 32'hDEADBEEF, be 4'b0101 onto 32'h11223344 -> next-cycle AXI read of 7 returns 32'h11AD33EF.
- Out of range: AXI read addr 600 and display read addr 1023 -> both granted, mem_en = 0, rdata = 0 with rvalid; AXI write addr 700 leaves VRAM unchanged.
- Write-then-display-read ordering: AXI write addr 2 granted at cycle N, display read addr 2 at N+1 -> disp_rdata equals the new data.
- Reset mid-read: assert axi_aresetn = 0 in the cycle after a display grant -> disp_rvalid never rises; after release, run_cnt = 0 and a single AXI request is granted immediately.
